// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-control bundle between the core front end and the PC sequencer.
// Rev 1.0
`default_nettype none

interface pc_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  stall;
  logic [1:0]            pc_src;
  logic [DATA_WIDTH-1:0] imm_op;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  trap;
  logic                  call;
  logic                  ret;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pcplus4;
  logic [DATA_WIDTH-1:0] ras_top;
  logic                  ras_empty;
  logic                  misalign;

  modport master (
    output stall, pc_src, imm_op, alu_result, trap, call, ret,
    input  pc, pcplus4, ras_top, ras_empty, misalign
  );

  modport slave (
    input  stall, pc_src, imm_op, alu_result, trap, call, ret,
    output pc, pcplus4, ras_top, ras_empty, misalign
  );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC with trap redirect, misalignment detection and a circular RAS.
// Rev 1.0
`default_nettype none

module pc_sequencer #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int                    RAS_DEPTH    = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pc_sequencer_if.slave    bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(RAS_DEPTH);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  misalign_q, misalign_d;
  logic [PTR_W-1:0]      wp_q, wp_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [DATA_WIDTH-1:0] ras_d [RAS_DEPTH];

  logic [DATA_WIDTH-1:0] w_pcplus4, w_cand, w_target, w_top;
  logic [PTR_W-1:0]      w_top_idx;
  logic                  w_empty, w_pop, w_push, w_mis;

  assign w_pcplus4 = pc_q + DATA_WIDTH'(4);
  assign w_top_idx = wp_q - PTR_W'(1);
  assign w_empty   = (cnt_q == '0);
  assign w_top     = w_empty ? '0 : ras_q[w_top_idx];

  always_comb begin
    w_cand = w_pcplus4;
    unique case (bus.pc_src)
      2'b00: w_cand = w_pcplus4;
      2'b01: w_cand = pc_q + bus.imm_op;
      2'b10: w_cand = bus.imm_op;
      2'b11: w_cand = {bus.alu_result[DATA_WIDTH-1:1], 1'b0};
    endcase
  end

  // A return with an empty stack falls back to the JALR path.
  assign w_pop    = bus.ret && !w_empty;
  assign w_target = w_pop ? w_top :
                    bus.ret ? {bus.alu_result[DATA_WIDTH-1:1], 1'b0} : w_cand;
  assign w_mis    = (w_target[1:0] != 2'b00);
  assign w_push   = bus.call && !w_mis;

  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    wp_d       = wp_q;
    cnt_d      = cnt_q;
    ras_d      = ras_q;
    if (bus.trap) begin
      pc_d       = TRAP_VECTOR;
      misalign_d = 1'b0;
    end else if (!bus.stall) begin
      pc_d       = w_mis ? TRAP_VECTOR : w_target;
      misalign_d = w_mis;
      if (w_pop && w_push) begin
        ras_d[w_top_idx] = w_pcplus4;
      end else if (w_pop) begin
        wp_d  = wp_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end else if (w_push) begin
        ras_d[wp_q] = w_pcplus4;
        wp_d        = wp_q + PTR_W'(1);
        cnt_d       = (cnt_q == C_FULL) ? cnt_q : cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
      wp_q       <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      wp_q       <= wp_d;
      cnt_q      <= cnt_d;
      ras_q      <= ras_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pcplus4   = w_pcplus4;
  assign bus.ras_top   = w_top;
  assign bus.ras_empty = w_empty;
  assign bus.misalign  = misalign_q;
endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with hand-computed expectations for pc_sequencer.
// Rev 1.0
`default_nettype none

module tb_pc_sequencer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  pc_sequencer_if #(.DATA_WIDTH(32)) bus ();

  pc_sequencer #(
    .DATA_WIDTH  (32),
    .RESET_VECTOR(32'h0000_0080),
    .TRAP_VECTOR (32'h0000_0100),
    .RAS_DEPTH   (4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu,
                       input logic c, input logic r);
    bus.pc_src     = src;
    bus.imm_op     = imm;
    bus.alu_result = alu;
    bus.call       = c;
    bus.ret        = r;
  endtask

  initial begin
    logic [31:0] exp_ret [5];
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.stall = 1'b0;
    bus.trap  = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset and idle sequencing
    #12;
    check("rst_pc", bus.pc, 32'h80);
    check("rst_empty", {31'b0, bus.ras_empty}, 32'h1);
    check("rst_mis", {31'b0, bus.misalign}, 32'h0);
    check("rst_top", bus.ras_top, 32'h0);
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("idle_pc", bus.pc, 32'h80 + 32'(4 * i));
    end
    check("idle_empty", {31'b0, bus.ras_empty}, 32'h1);
    check("idle_mis", {31'b0, bus.misalign}, 32'h0);

    // Call and return
    drive(2'b10, 32'h10, 32'h0, 1'b0, 1'b0); step();
    check("jal_pc", bus.pc, 32'h10);
    drive(2'b10, 32'h200, 32'h0, 1'b1, 1'b0); step();
    check("call_pc", bus.pc, 32'h200);
    check("call_top", bus.ras_top, 32'h14);
    check("call_empty", {31'b0, bus.ras_empty}, 32'h0);
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1); step();
    check("ret_pc", bus.pc, 32'h14);
    check("ret_empty", {31'b0, bus.ras_empty}, 32'h1);

    // Overflow: five nested calls into a 4-deep stack
    drive(2'b10, 32'h0, 32'h0, 1'b0, 1'b0); step();
    check("jal0_pc", bus.pc, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      drive(2'b10, 32'(i * 32'h100), 32'h0, 1'b1, 1'b0); step();
      check("nest_pc", bus.pc, 32'(i * 32'h100));
    end
    check("nest_top", bus.ras_top, 32'h404);
    exp_ret[0] = 32'h404; exp_ret[1] = 32'h304; exp_ret[2] = 32'h204;
    exp_ret[3] = 32'h104; exp_ret[4] = 32'h800;
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, 32'h0, 32'h800, 1'b0, 1'b1); step();
      check("unwind_pc", bus.pc, exp_ret[i]);
    end
    check("unwind_empty", {31'b0, bus.ras_empty}, 32'h1);

    // Stall holds everything, trap overrides stall
    drive(2'b10, 32'h900, 32'h0, 1'b1, 1'b0); step();
    check("call2_top", bus.ras_top, 32'h804);
    bus.stall = 1'b1;
    drive(2'b01, 32'h40, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", bus.pc, 32'h900);
      check("stall_top", bus.ras_top, 32'h804);
    end
    bus.trap = 1'b1; step();
    check("trap_pc", bus.pc, 32'h100);
    check("trap_top", bus.ras_top, 32'h804);
    check("trap_mis", {31'b0, bus.misalign}, 32'h0);
    bus.trap  = 1'b0;
    bus.stall = 1'b0;

    // Misaligned and wrapping targets
    drive(2'b11, 32'h0, 32'h203, 1'b0, 1'b0); step();
    check("mis_pc", bus.pc, 32'h100);
    check("mis_flag", {31'b0, bus.misalign}, 32'h1);
    drive(2'b11, 32'h0, 32'h205, 1'b0, 1'b0); step();
    check("jalr_pc", bus.pc, 32'h204);
    check("mis_clear", {31'b0, bus.misalign}, 32'h0);
    drive(2'b10, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0); step();
    check("top_pc", bus.pc, 32'hFFFF_FFFC);
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0); step();
    check("wrap_pc", bus.pc, 32'h0);
    drive(2'b01, 32'h40, 32'h0, 1'b0, 1'b0); step();
    check("branch_pc", bus.pc, 32'h40);
    drive(2'b10, 32'h302, 32'h0, 1'b1, 1'b0); step();
    check("miscall_pc", bus.pc, 32'h100);
    check("miscall_flag", {31'b0, bus.misalign}, 32'h1);
    check("miscall_top", bus.ras_top, 32'h804);

    // Replace-top with call and ret together at cnt = 1
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b1); step();
    check("repl_pc", bus.pc, 32'h804);
    check("repl_top", bus.ras_top, 32'h104);
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1); step();
    check("repl_ret_pc", bus.pc, 32'h104);
    check("repl_empty", {31'b0, bus.ras_empty}, 32'h1);

    // Asynchronous reset between edges with two entries stacked
    drive(2'b10, 32'h1000, 32'h0, 1'b1, 1'b0); step();
    drive(2'b10, 32'h2000, 32'h0, 1'b1, 1'b0); step();
    check("pre_rst_top", bus.ras_top, 32'h1004);
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("arst_pc", bus.pc, 32'h80);
    check("arst_empty", {31'b0, bus.ras_empty}, 32'h1);
    check("arst_top", bus.ras_top, 32'h0);
    rst = 1'b1;
    step();
    check("post_rst_pc", bus.pc, 32'h84);

    // call and ret with an empty stack: push only, pc follows alu_result
    drive(2'b00, 32'h0, 32'h3000, 1'b1, 1'b1); step();
    check("cr_empty_pc", bus.pc, 32'h3000);
    check("cr_empty_top", bus.ras_top, 32'h88);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
